// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: weight-stationary multiply-accumulate tile of the systolic
// matrix engine. Activations flow west->east, partial sums north->south and
// weights shift down the column into a shadow register that is swapped into
// the active register on w_swap, so the next tile's weights load while the
// current tile computes.
//
// Build option: define SYSTOLIC_MAC_PE_SAT_EN to clamp the accumulation to the
// ACC_W range and add the sticky sat_flag output. Without it the sum wraps.
module systolic_mac_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic              a_valid,
  output logic [DATA_W-1:0] a_out,
  output logic              a_valid_out,
  input  logic [ACC_W-1:0]  psum_in,
  input  logic              psum_valid_in,
  output logic [ACC_W-1:0]  psum_out,
  output logic              psum_valid_out,
  input  logic [DATA_W-1:0] w_in,
  input  logic              w_shift,
  output logic [DATA_W-1:0] w_out,
  input  logic              w_swap,
  output logic              shadow_full,
`ifdef SYSTOLIC_MAC_PE_SAT_EN
  output logic              sat_flag,
`endif
  output logic              swap_err
);

  // Operand interpretation: 1 = two's complement, 0 = unsigned.
  localparam logic SGN = (SIGNED != 0);

  // The wrap build only needs ACC_W bits; the saturating build keeps one
  // extra bit so overflow is visible before clamping.
`ifdef SYSTOLIC_MAC_PE_SAT_EN
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } w_state_t;

  w_state_t          w_state;
  logic [DATA_W-1:0] w_shadow;
  logic [DATA_W-1:0] w_active;

  logic [2*DATA_W-1:0] a_x;
  logic [2*DATA_W-1:0] w_x;
  logic [2*DATA_W-1:0] prod;
  logic [SUM_W-1:0]    prod_ext;
  logic [SUM_W-1:0]    addend;
  logic [SUM_W-1:0]    sum;
  logic [ACC_W-1:0]    mac_result;
  logic                mac_clamp;

  assign w_out       = w_shadow;
  assign shadow_full = (w_state == FULL);

  // Weight double buffer: shadow loads from the column chain, swap copies it
  // into the active weight. A swap with nothing buffered is flagged, not done.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values, which is what lets shift+swap hand the old shadow to
  // active while the shadow takes w_in in the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state  <= EMPTY;
      w_shadow <= '0;
      w_active <= '0;
      swap_err <= 1'b0;
    end else begin
      if (w_swap) begin
        if (w_state == FULL) begin
          w_active <= w_shadow;
        end else begin
          swap_err <= 1'b1;
        end
      end
      if (w_shift) begin
        w_shadow <= w_in;
        w_state  <= FULL;
      end else if (w_swap && (w_state == FULL)) begin
        w_state <= EMPTY;
      end
    end
  end

  // Multiply and accumulate datapath, sign- or zero-extended per SGN.
  // NOTE: every output of this block gets a value on every path, so no
  // latch is inferred.
  always_comb begin
    a_x      = {{DATA_W{SGN & a_in[DATA_W-1]}}, a_in};
    w_x      = {{DATA_W{SGN & w_active[DATA_W-1]}}, w_active};
    prod     = a_x * w_x;
    prod_ext = SUM_W'($signed({SGN & prod[2*DATA_W-1], prod}));
    addend   = psum_valid_in ? SUM_W'($signed({SGN & psum_in[ACC_W-1], psum_in})) : '0;
    sum      = prod_ext + addend;
  end

  // Final result: clamp to the ACC_W range, or plain modulo-2^ACC_W wrap.
  always_comb begin
    mac_result = sum[ACC_W-1:0];
    mac_clamp  = 1'b0;
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    if (SGN) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        mac_clamp  = 1'b1;
        mac_result = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (sum[ACC_W]) begin
      mac_clamp  = 1'b1;
      mac_result = '1;
    end
`endif
  end

  // Partial-sum register: MAC on a valid activation, otherwise bypass a valid
  // psum_in or hold the previous value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psum_out       <= '0;
      psum_valid_out <= 1'b0;
`ifdef SYSTOLIC_MAC_PE_SAT_EN
      sat_flag       <= 1'b0;
`endif
    end else if (a_valid) begin
      psum_out       <= mac_result;
      psum_valid_out <= 1'b1;
`ifdef SYSTOLIC_MAC_PE_SAT_EN
      if (mac_clamp) begin
        sat_flag <= 1'b1;
      end
`endif
    end else begin
      psum_valid_out <= psum_valid_in;
      if (psum_valid_in) begin
        psum_out <= psum_in;
      end
    end
  end

  // Activation forwarding east; data holds while the lane is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out       <= '0;
      a_valid_out <= 1'b0;
    end else begin
      a_valid_out <= a_valid;
      if (a_valid) begin
        a_out <= a_in;
      end
    end
  end

`ifndef SYSTOLIC_MAC_PE_SAT_EN
  // Only the saturating build consumes the clamp indication.
  logic unused_clamp;
  assign unused_clamp = mac_clamp;
`endif

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Directed testbench for systolic_mac_pe (DATA_W=8, ACC_W=32, SIGNED=1).
// Covers both builds: define SYSTOLIC_MAC_PE_SAT_EN to exercise saturation.
module tb_systolic_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  a_in;
  logic        a_valid;
  logic [7:0]  a_out;
  logic        a_valid_out;
  logic [31:0] psum_in;
  logic        psum_valid_in;
  logic [31:0] psum_out;
  logic        psum_valid_out;
  logic [7:0]  w_in;
  logic        w_shift;
  logic [7:0]  w_out;
  logic        w_swap;
  logic        shadow_full;
  logic        swap_err;
`ifdef SYSTOLIC_MAC_PE_SAT_EN
  logic        sat_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_mac_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_in           (a_in),
    .a_valid        (a_valid),
    .a_out          (a_out),
    .a_valid_out    (a_valid_out),
    .psum_in        (psum_in),
    .psum_valid_in  (psum_valid_in),
    .psum_out       (psum_out),
    .psum_valid_out (psum_valid_out),
    .w_in           (w_in),
    .w_shift        (w_shift),
    .w_out          (w_out),
    .w_swap         (w_swap),
    .shadow_full    (shadow_full),
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    .sat_flag       (sat_flag),
`endif
    .swap_err       (swap_err)
  );

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    a_valid       = 1'b0;
    psum_valid_in = 1'b0;
    w_shift       = 1'b0;
    w_swap        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; a_in = '0; psum_in = '0; w_in = '0;
    clear_strobes();
    tick(); tick();
    n_cmp++; if (psum_out !== 32'd0) begin n_err++; $display("FAIL reset_psum: got %h want 0", psum_out); end
    n_cmp++; if ({a_out, a_valid_out, psum_valid_out} !== 10'd0) begin n_err++; $display("FAIL reset_a: got a_out=%h av=%b pv=%b want 0", a_out, a_valid_out, psum_valid_out); end
    n_cmp++; if ({w_out, shadow_full, swap_err} !== 10'd0) begin n_err++; $display("FAIL reset_w: got w_out=%h full=%b err=%b want 0", w_out, shadow_full, swap_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_mac();
    w_in = 8'd3; w_shift = 1'b1;
    tick(); clear_strobes();
    n_cmp++; if ({w_out, shadow_full} !== {8'd3, 1'b1}) begin n_err++; $display("FAIL shift_load: got w_out=%h full=%b want 03/1", w_out, shadow_full); end
    w_swap = 1'b1;
    tick(); clear_strobes();
    n_cmp++; if (shadow_full !== 1'b0) begin n_err++; $display("FAIL swap_empty: got %b want 0", shadow_full); end
    a_in = 8'hFC; a_valid = 1'b1; psum_in = 32'd100; psum_valid_in = 1'b1;
    tick(); clear_strobes();
    n_cmp++; if (psum_out !== 32'd88) begin n_err++; $display("FAIL basic_psum: got %0d want 88", psum_out); end
    n_cmp++; if (psum_valid_out !== 1'b1) begin n_err++; $display("FAIL basic_pvalid: got %b want 1", psum_valid_out); end
    n_cmp++; if ({a_out, a_valid_out} !== {8'hFC, 1'b1}) begin n_err++; $display("FAIL basic_a_fwd: got %h/%b want fc/1", a_out, a_valid_out); end
  endtask

  task automatic test_double_buffer();
    w_in = 8'd2; w_shift = 1'b1; tick(); clear_strobes();
    w_swap = 1'b1; tick(); clear_strobes();
    w_in = 8'd5; w_shift = 1'b1; tick(); clear_strobes();
    w_swap = 1'b1; a_in = 8'd10; a_valid = 1'b1;
    tick(); w_swap = 1'b0;
    n_cmp++; if (psum_out !== 32'd20) begin n_err++; $display("FAIL dbuf_old_weight: got %0d want 20", psum_out); end
    tick(); clear_strobes();
    n_cmp++; if (psum_out !== 32'd50) begin n_err++; $display("FAIL dbuf_new_weight: got %0d want 50", psum_out); end
  endtask

  task automatic test_swap_err();
    w_swap = 1'b1; tick(); clear_strobes();
    n_cmp++; if ({swap_err, shadow_full} !== 2'b10) begin n_err++; $display("FAIL swap_err_set: got err=%b full=%b want 1/0", swap_err, shadow_full); end
    a_in = 8'd3; a_valid = 1'b1; tick(); clear_strobes();
    n_cmp++; if (psum_out !== 32'd15) begin n_err++; $display("FAIL swap_err_active_kept: got %0d want 15", psum_out); end
    w_in = 8'd7; w_shift = 1'b1; tick(); clear_strobes();
    w_in = 8'd9; w_shift = 1'b1; w_swap = 1'b1; tick(); clear_strobes();
    n_cmp++; if ({w_out, shadow_full} !== {8'd9, 1'b1}) begin n_err++; $display("FAIL shift_swap_shadow: got w_out=%h full=%b want 09/1", w_out, shadow_full); end
    a_in = 8'd2; a_valid = 1'b1; tick(); clear_strobes();
    n_cmp++; if (psum_out !== 32'd14) begin n_err++; $display("FAIL shift_swap_active: got %0d want 14", psum_out); end
    n_cmp++; if (swap_err !== 1'b1) begin n_err++; $display("FAIL swap_err_sticky: got %b want 1", swap_err); end
  endtask

  task automatic test_bypass();
    a_in = 8'h55; psum_in = 32'h1234; psum_valid_in = 1'b1;
    tick(); clear_strobes();
    n_cmp++; if ({psum_out, psum_valid_out} !== {32'h1234, 1'b1}) begin n_err++; $display("FAIL bypass: got %h/%b want 1234/1", psum_out, psum_valid_out); end
    n_cmp++; if ({a_out, a_valid_out} !== {8'd2, 1'b0}) begin n_err++; $display("FAIL idle_a_hold: got %h/%b want 02/0", a_out, a_valid_out); end
    psum_in = 32'hDEAD;
    tick();
    n_cmp++; if ({psum_out, psum_valid_out} !== {32'h1234, 1'b0}) begin n_err++; $display("FAIL idle_hold: got %h/%b want 1234/0", psum_out, psum_valid_out); end
  endtask

  task automatic test_overflow();
    w_in = 8'd1; w_shift = 1'b1; tick(); clear_strobes();
    w_swap = 1'b1; tick(); clear_strobes();
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_flag_clear: got %b want 0", sat_flag); end
`endif
    a_in = 8'd1; a_valid = 1'b1; psum_in = 32'h7FFF_FFFF; psum_valid_in = 1'b1;
    tick(); clear_strobes();
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    n_cmp++; if (psum_out !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_pos: got %h want 7fffffff", psum_out); end
    n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_flag_set: got %b want 1", sat_flag); end
`else
    n_cmp++; if (psum_out !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_pos: got %h want 80000000", psum_out); end
`endif
    a_in = 8'hFF; a_valid = 1'b1; psum_in = 32'h8000_0000; psum_valid_in = 1'b1;
    tick(); clear_strobes();
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    n_cmp++; if (psum_out !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_neg: got %h want 80000000", psum_out); end
`else
    n_cmp++; if (psum_out !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL ovf_neg: got %h want 7fffffff", psum_out); end
`endif
  endtask

  task automatic test_reset_midstream();
    w_in = 8'd4; w_shift = 1'b1; tick(); clear_strobes();
    a_in = 8'd6; a_valid = 1'b1; psum_in = 32'd10; psum_valid_in = 1'b1;
    tick();
    n_cmp++; if (psum_out !== 32'd16) begin n_err++; $display("FAIL pre_reset_mac: got %0d want 16", psum_out); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({psum_out, psum_valid_out} !== 33'd0) begin n_err++; $display("FAIL midreset_psum: got %h/%b want 0/0", psum_out, psum_valid_out); end
    n_cmp++; if ({a_out, a_valid_out, w_out, shadow_full, swap_err} !== 19'd0) begin n_err++; $display("FAIL midreset_state: got a=%h av=%b w=%h full=%b err=%b want 0", a_out, a_valid_out, w_out, shadow_full, swap_err); end
`ifdef SYSTOLIC_MAC_PE_SAT_EN
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL midreset_sat: got %b want 0", sat_flag); end
`endif
    clear_strobes();
    tick();
    rst = 1'b1;
    a_in = 8'd5; a_valid = 1'b1; psum_in = 32'd7; psum_valid_in = 1'b1;
    tick(); clear_strobes();
    n_cmp++; if ({psum_out, psum_valid_out} !== {32'd7, 1'b1}) begin n_err++; $display("FAIL post_reset_mac: got %0d/%b want 7/1", psum_out, psum_valid_out); end
  endtask

  initial begin
    test_reset();
    test_basic_mac();
    test_double_buffer();
    test_swap_err();
    test_bypass();
    test_overflow();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_mac_pe.md
# systolic_mac_pe

- Parametrised weight-stationary multiply-accumulate processing element, the tile of the systolic matrix engine.
- Activations enter from the west and are forwarded east. Partial sums enter from the north and leave south. Weights are shifted down each column into a shadow register and swapped into the active register on command, so the next tile's weights load while the current tile computes.
- Adds over the first-generation PE: configurable widths, signed/unsigned arithmetic, per-lane valid qualification, double-buffered weights with swap-error detection, and optional saturation.

## Interface
Parameters:
- DATA_W, 8, activation and weight width.
- ACC_W, 32, partial-sum width; must be >= 2*DATA_W.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- a_in  in  DATA_W  activation from west.
- a_valid  in  1  a_in qualifier.
- a_out  out  DATA_W  registered activation to east.
- a_valid_out  out  1  registered a_valid.
- psum_in  in  ACC_W  partial sum from north.
- psum_valid_in  in  1  psum_in qualifier; 0 means psum_in is treated as zero.
- psum_out  out  ACC_W  registered partial sum to south.
- psum_valid_out  out  1  psum_out qualifier.
- w_in  in  DATA_W  weight shift-chain input from north.
- w_shift  in  1  shift strobe for the column weight chain.
- w_out  out  DATA_W  shadow register value, feeding the south neighbour's w_in.
- w_swap  in  1  copy shadow into active weight.
- shadow_full  out  1  shadow holds a weight not yet swapped.
- swap_err  out  1  sticky: w_swap seen while shadow_full = 0.

## Operation
Reset:
- All registers clear.
- a_out, psum_out, w_out = 0.
- All valid and status outputs = 0.

Weight buffer FSM, two states, encoded by shadow_full:
- EMPTY: w_shift loads shadow <= w_in and moves to FULL. A w_swap in EMPTY sets swap_err; the active weight is unchanged.
- FULL: w_shift reloads shadow and stays FULL. w_swap sets active <= shadow and moves to EMPTY.
- w_shift and w_swap in the same cycle: active takes the old shadow, shadow takes w_in, state remains FULL.
- swap_err clears only on reset.

Weight chain:
- w_out is driven directly from the shadow register.
- N shift pulses load an N-row column; the last weight shifted in lands in row 0.

MAC, on a cycle with a_valid = 1:
- product = a_in * active, 2*DATA_W bits, signed or unsigned per SIGNED.
- product is sign- or zero-extended to ACC_W.
- psum_out <= ext(product) + (psum_valid_in ? psum_in : 0).
- psum_valid_out <= 1.
- Without saturation, the sum wraps modulo 2^ACC_W.

Idle cycle, a_valid = 0:
- psum_out holds its value.
- psum_valid_out <= psum_valid_in. A psum_in with psum_valid_in = 1 and no activation passes through to psum_out unchanged (bypass).

Activation forwarding:
- a_out <= a_in and a_valid_out <= a_valid every cycle.
- When a_valid = 0, a_out holds its previous value.

## Timing
- Activation forward latency: 1 cycle. Partial-sum latency: 1 cycle. Weight chain latency: 1 cycle per PE.
- Swap takes effect from the next edge. A MAC in the same cycle as w_swap uses the old active weight; the following cycle uses the new one.
- Asserting rst mid-operation immediately clears all state, including an in-flight psum and the shadow weight. Operation resumes on the first edge after rst is deasserted.
- No backpressure. The array controller guarantees the wavefront skew.

## Configuration
- Macro SYSTOLIC_MAC_PE_SAT_EN.
- When defined:
  - The sum is computed at ACC_W+1 bits and clamped to the ACC_W range: signed min/max if SIGNED = 1, otherwise 0 / 2^ACC_W−1.
  - A sticky output sat_flag (1 bit, reset 0) is added and set on any clamp.
- When undefined: wrap-around arithmetic, and no sat_flag port.

## Test plan
- Reset: drive rst = 0 mid-stream. All outputs read 0 immediately; shadow_full = 0, swap_err = 0.
- Basic MAC, SIGNED = 1, DATA_W = 8, ACC_W = 32: shift 3, swap, then a_in = −4 with psum_in = 100 (valid) -> psum_out = 88, psum_valid_out = 1 one cycle later; a_out = −4.
- Double buffer: weight 2 active, shift 5 into the shadow, MAC a = 10 in the swap cycle and again the cycle after -> 20, then 50 (psum_in invalid).
- Swap error: w_swap with shadow_full = 0 -> swap_err = 1 and stays 1, active weight unchanged. Simultaneous shift+swap with shadow = 7, w_in = 9 -> active = 7, shadow = 9, shadow_full = 1.
- Bypass/idle: a_valid = 0, psum_in = 0x1234 with psum_valid_in = 1 -> psum_out = 0x1234. With psum_valid_in = 0 -> psum_out held, psum_valid_out = 0.
- Overflow: psum_in = 0x7FFFFFFF, a = 1, w = 1. With the macro undefined -> 0x80000000. With SYSTOLIC_MAC_PE_SAT_EN defined -> 0x7FFFFFFF and sat_flag = 1.
